// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one 74381-style ALU between two requesters.
// Optional grant statistics are enabled with ALU_SHARE_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_S,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_S,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic [2:0]       alu_S,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_Cin,
  input  logic [WIDTH-1:0] alu_F,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_F,
  output logic             rsp_zero
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_grant0,
  output logic [15:0]      stat_grant1
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [2:0]       alu_s_q, alu_s_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant0_c, grant1_c;
  logic [2:0]       sel_s_c;
  logic [WIDTH-1:0] sel_a_c, sel_b_c;

  // Arbitration: ties go to the requester that was not granted last.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  assign sel_s_c = grant1_c ? req1_S : req0_S;
  assign sel_a_c = grant1_c ? req1_A : req0_A;
  assign sel_b_c = grant1_c ? req1_B : req0_B;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    alu_s_d      = alu_s_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_f_d      = rsp_f_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0_c || grant1_c) begin
          alu_s_d      = sel_s_c;
          alu_a_d      = sel_a_c;
          alu_b_d      = sel_b_c;
          // Both subtract functions need the borrow-free carry-in.
          alu_cin_d    = (sel_s_c == 3'b001) || (sel_s_c == 3'b010);
          last_grant_d = grant1_c;
          grant_id_d   = grant1_c;
          cnt_d        = CNT_W'(SETTLE - 1);
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          rsp_f_d     = alu_F;
          rsp_zero_d  = (alu_F == '0);
          rsp_id_d    = grant_id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      alu_s_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_f_q      <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      alu_s_q      <= alu_s_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_f_q      <= rsp_f_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_S     = alu_s_q;
  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign alu_Cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_F     = rsp_f_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [STAT_W-1:0] stat0_q, stat0_d;
  logic [STAT_W-1:0] stat1_q, stat1_d;

  // Saturating accept counters; clear wins over a same-cycle accept.
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (stat_clr) begin
      stat0_d = '0;
      stat1_d = '0;
    end else begin
      if (grant0_c && (stat0_q != '1)) stat0_d = stat0_q + STAT_W'(1);
      if (grant1_c && (stat1_q != '1)) stat1_d = stat1_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat_grant0 = stat0_q;
  assign stat_grant1 = stat1_q;
`else
  localparam int unsigned STAT_UNUSED = STAT_W;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table-driven ops, scoreboard, corner sequences.
module tb_alu_share_arbiter;

  localparam int unsigned W      = 16;
  localparam int unsigned SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_S, req1_S, alu_S;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B, alu_A, alu_B, alu_F, rsp_F;
  logic         alu_Cin, rsp_valid, rsp_ready, rsp_id, rsp_zero;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic         stat_clr;
  logic [15:0]  stat_grant0, stat_grant1;
`endif

  alu_share_arbiter #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_S(req0_S), .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_S(req1_S), .req1_A(req1_A), .req1_B(req1_B),
    .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_F(alu_F),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_F(rsp_F), .rsp_zero(rsp_zero)
`ifdef ALU_SHARE_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 74381 ALU; carry-in is honoured so a wrong alu_Cin corrupts F.
  always_comb begin
    case (alu_S)
      3'b000:  alu_F = '0;
      3'b001:  alu_F = alu_B + ~alu_A + W'(alu_Cin);
      3'b010:  alu_F = alu_A + ~alu_B + W'(alu_Cin);
      3'b011:  alu_F = alu_A + alu_B + W'(alu_Cin);
      3'b100:  alu_F = alu_A ^ alu_B;
      3'b101:  alu_F = alu_A | alu_B;
      3'b110:  alu_F = alu_A & alu_B;
      default: alu_F = '1;
    endcase
  end

  typedef struct {
    logic         id;
    logic [2:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic         z;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] f;
    logic         z;
  } exp_t;

  exp_t   exp_q[$];
  int     acc_q[$];
  logic   rsp_ids[$];
  exp_t   e_m;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     n_ready0 = 0;
  int     n_ready1 = 0;
  logic   saw_valid = 1'b0;
  logic   chk_pend = 1'b0;
  logic [2:0]   chk_s;
  logic [W-1:0] chk_a, chk_b;
  vec_t   vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: ALU drive after accept, latency, ready legality and response scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      chk_pend  = 1'b0;
      saw_valid = 1'b0;
    end else begin
      if (chk_pend) begin
        chk("exec_alu_S", 32'(alu_S), 32'(chk_s));
        chk("exec_alu_A", 32'(alu_A), 32'(chk_a));
        chk("exec_alu_B", 32'(alu_B), 32'(chk_b));
        chk("exec_alu_Cin", 32'(alu_Cin), 32'((chk_s == 3'b001) || (chk_s == 3'b010)));
        chk_pend = 1'b0;
      end
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid) || (req0_ready && req1_ready))
        chk("ready_legal", 32'(1), 32'(0));
      if (req0_ready) n_ready0++;
      if (req1_ready) n_ready1++;
      if (req0_ready || req1_ready) begin
        acc_q.push_back(cyc);
        chk_pend = 1'b1;
        chk_s = req1_ready ? req1_S : req0_S;
        chk_a = req1_ready ? req1_A : req0_A;
        chk_b = req1_ready ? req1_B : req0_B;
      end
      if (rsp_valid && !saw_valid) begin
        saw_valid = 1'b1;
        if (acc_q.size() == 0) chk("latency_no_accept", 32'(1), 32'(0));
        else chk("latency", 32'(cyc), 32'(acc_q.pop_front() + int'(SETTLE) + 1));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(1), 32'(0));
        end else begin
          e_m = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e_m.id));
          chk("rsp_F", 32'(rsp_F), 32'(e_m.f));
          chk("rsp_zero", 32'(rsp_zero), 32'(e_m.z));
        end
        rsp_ids.push_back(rsp_id);
        saw_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] f, input logic z);
    exp_t e;
    e.id = id; e.f = f; e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic issue(input vec_t v);
    logic got = 1'b0;
    if (v.id) begin
      req1_valid = 1'b1; req1_S = v.s; req1_A = v.a; req1_B = v.b;
    end else begin
      req0_valid = 1'b1; req0_S = v.s; req0_A = v.a; req0_B = v.b;
    end
    push_exp(v.id, v.f, v.z);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = v.id ? req1_ready : req0_ready;
    end
    if (!got) chk("accept_timeout", 32'(0), 32'(1));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic got;
    int n0, n1;
    vecs[0] = '{1'b0, 3'b011, 16'h1234, 16'h0F0F, 16'h2143, 1'b0};
    vecs[1] = '{1'b1, 3'b010, 16'h0005, 16'h0005, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 3'b001, 16'h0001, 16'h0003, 16'h0002, 1'b0};
    vecs[3] = '{1'b1, 3'b100, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0};
    vecs[4] = '{1'b0, 3'b101, 16'h1200, 16'h0034, 16'h1234, 1'b0};
    vecs[5] = '{1'b1, 3'b110, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
    vecs[6] = '{1'b0, 3'b000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 3'b111, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
    vecs[8] = '{1'b0, 3'b011, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[9] = '{1'b1, 3'b010, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_S = 3'b011; req0_A = 16'h1234; req0_B = 16'h0F0F;
    req1_valid = 1'b1; req1_S = 3'b010; req1_A = 16'h0005; req1_B = 16'h0005;
`ifdef ALU_SHARE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset held with both requesters pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'(0));
      chk("rst_req1_ready", 32'(req1_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    end
    chk("rst_alu_S", 32'(alu_S), 32'(0));
    chk("rst_alu_A", 32'(alu_A), 32'(0));
    chk("rst_alu_B", 32'(alu_B), 32'(0));
    chk("rst_alu_Cin", 32'(alu_Cin), 32'(0));
    chk("rst_rsp_F", 32'(rsp_F), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_zero", 32'(rsp_zero), 32'(0));
    tick();
    rst_n = 1'b1;
    push_exp(1'b0, 16'h2143, 1'b0);
    @(negedge clk);
    chk("first_grant_req0", 32'(req0_ready), 32'(1));
    chk("first_grant_not_req1", 32'(req1_ready), 32'(0));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain(20);

    // Function table, one op at a time.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      wait_drain(20);
    end

    // Round-robin with both requesters continuously valid (last grant was req1).
    n0 = n_ready0; n1 = n_ready1;
    rsp_ids.delete();
    push_exp(1'b0, 16'h0003, 1'b0); push_exp(1'b1, 16'h0FF0, 1'b0);
    push_exp(1'b0, 16'h0003, 1'b0); push_exp(1'b1, 16'h0FF0, 1'b0);
    req0_valid = 1'b1; req0_S = 3'b011; req0_A = 16'h0001; req0_B = 16'h0002;
    req1_valid = 1'b1; req1_S = 3'b100; req1_A = 16'h00FF; req1_B = 16'h0F0F;
    k = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) k++;
    end
    chk("rr_accepts", 32'(k), 32'(4));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain(20);
    chk("rr_ready0_pulses", 32'(n_ready0 - n0), 32'(2));
    chk("rr_ready1_pulses", 32'(n_ready1 - n1), 32'(2));
    chk("rr_rsp_count", 32'(rsp_ids.size()), 32'(4));
    if (rsp_ids.size() == 4) begin
      chk("rr_seq0", 32'(rsp_ids[0]), 32'(0));
      chk("rr_seq1", 32'(rsp_ids[1]), 32'(1));
      chk("rr_seq2", 32'(rsp_ids[2]), 32'(0));
      chk("rr_seq3", 32'(rsp_ids[3]), 32'(1));
    end

    // Backpressure in RESP with req1 waiting.
    rsp_ready = 1'b0;
    issue('{1'b0, 3'b011, 16'h0010, 16'h0020, 16'h0030, 1'b0});
    req1_valid = 1'b1; req1_S = 3'b101; req1_A = 16'h0F00; req1_B = 16'h00F0;
    push_exp(1'b1, 16'h0FF0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("bp_rsp_valid_seen", 32'(got), 32'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_F", 32'(rsp_F), 32'(16'h0030));
      chk("bp_no_ready", 32'(req1_ready), 32'(0));
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_accept", 32'(req1_ready), 32'(0));
    @(negedge clk);
    chk("bp_next_accept", 32'(req1_ready), 32'(1));
    chk("bp_valid_dropped", 32'(rsp_valid), 32'(0));
    tick();
    req1_valid = 1'b0;
    wait_drain(20);

    // Reset during EXEC aborts the op.
    issue('{1'b0, 3'b011, 16'h1111, 16'h1111, 16'h2222, 1'b0});
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
    end
    tick();

`ifdef ALU_SHARE_ARB_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue('{(i == 2), 3'b100, 16'h00AA, 16'h0055, 16'h00FF, 1'b0});
      wait_drain(20);
    end
    @(negedge clk);
    chk("stat_grant0", 32'(stat_grant0), 32'(3));
    chk("stat_grant1", 32'(stat_grant1), 32'(1));
    tick();
    stat_clr = 1'b1;
    req0_valid = 1'b1; req0_S = 3'b110; req0_A = 16'h00FF; req0_B = 16'h0F0F;
    push_exp(1'b0, 16'h000F, 1'b0);
    @(negedge clk);
    chk("clr_accept_ready", 32'(req0_ready), 32'(1));
    tick();
    stat_clr = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("clr_stat_grant0", 32'(stat_grant0), 32'(0));
    chk("clr_stat_grant1", 32'(stat_grant1), 32'(0));
    wait_drain(20);
`endif

    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
